sdt_issue: RTL and testbench

SDT_ISSUE -- requirements
Module: sdt_issue

---
 rtl/sdt_issue_pkg.sv | 82 ++++++++
 rtl/sdt_issue_cond_eval.sv | 38 +++
 rtl/sdt_issue.sv | 148 ++++++++++++++
 tb/tb_sdt_issue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sdt_issue_pkg.sv
// Shared definitions for the single-data-transfer issue block: FSM encoding,
// ARM condition codes, instruction field positions and the SDT decode helpers.
package sdt_issue_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RETIRE    = 3'd5;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int BIT_COND_LO  = 28;
  localparam int BIT_CLASS_HI = 27;
  localparam int BIT_CLASS_LO = 26;
  localparam int BIT_I        = 25;
  localparam int BIT_P        = 24;
  localparam int BIT_U        = 23;
  localparam int BIT_B        = 22;
  localparam int BIT_W        = 21;
  localparam int BIT_L        = 20;
  localparam int BIT_RN_LO    = 16;
  localparam int BIT_RD_LO    = 12;
  localparam int BIT_SHIFT_HI = 11;
  localparam int BIT_SHIFT_LO = 4;

  typedef enum logic [1:0] {
    RSN_NONE,
    RSN_SKIP,
    RSN_UNDEF,
    RSN_TIMEOUT
  } retire_rsn_e;

  typedef struct packed {
    logic        immediate;
    logic        pre;
    logic        up;
    logic        word;
    logic        write;
    logic        load;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] offset;
  } sdt_cmd_t;

  function automatic sdt_cmd_t sdt_decode(input logic [31:0] ins);
    sdt_cmd_t cmd;
    cmd.immediate = ~ins[BIT_I];
    cmd.pre       = ins[BIT_P];
    cmd.up        = ins[BIT_U];
    cmd.word      = ~ins[BIT_B];
    cmd.write     = ins[BIT_W];
    cmd.load      = ins[BIT_L];
    cmd.rn        = ins[BIT_RN_LO +: 4];
    cmd.rd        = ins[BIT_RD_LO +: 4];
    cmd.offset    = ins[11:0];
    return cmd;
  endfunction

  // Register-offset forms with a non-zero shift field cannot be executed downstream.
  function automatic logic sdt_is_undef(input logic [31:0] ins);
    return (ins[BIT_CLASS_HI:BIT_CLASS_LO] != 2'b01) ||
           (ins[BIT_I] && (ins[BIT_SHIFT_HI:BIT_SHIFT_LO] != 8'h00));
  endfunction

endpackage

// File: rtl/sdt_issue_cond_eval.sv
// ARMv4 condition-code evaluator; NV is treated as never passing.
module cond_eval
  import sdt_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdt_issue.sv
// Issues one ARM single-data-transfer instruction at a time to the transfer
// unit, waits for it to finish and reports completion, skip, undef or timeout.
module sdt_issue
  import sdt_issue_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [3:0]  flags,
  output logic        instr_ready,
  output logic        en,
  output logic        immediate,
  output logic        pre,
  output logic        up,
  output logic        word,
  output logic        write,
  output logic        load,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [11:0] offset,
  input  logic        busy,
  output logic        retire_valid,
  output logic        retire_skipped,
  output logic        retire_undef,
  output logic        retire_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  retire_rsn_e   rsn_q, rsn_d;
  logic          ready_q, ready_d;
  logic [31:0]   instr_q;
  logic [3:0]    flags_q;
  sdt_cmd_t      cmd_q;
  logic          accept, load_cmd, cond_pass;

  cond_eval u_cond_eval (
    .cond  (instr_q[BIT_COND_LO +: 4]),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign accept = instr_valid && ready_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsn_d    = rsn_q;
    load_cmd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (sdt_is_undef(instr_q)) begin
          state_d = S_RETIRE;
          rsn_d   = RSN_UNDEF;
        end else if (!cond_pass) begin
          state_d = S_RETIRE;
          rsn_d   = RSN_SKIP;
        end else begin
          state_d  = S_ISSUE;
          rsn_d    = RSN_NONE;
          load_cmd = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (!busy) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_RETIRE;
          rsn_d   = RSN_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          state_d = S_RETIRE;
          rsn_d   = RSN_NONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RETIRE;
          rsn_d   = RSN_TIMEOUT;
          cnt_d   = CW'(TIMEOUT);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Ready is registered so it stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rsn_q   <= RSN_NONE;
      ready_q <= 1'b0;
      // NOTE: capture and command registers are reset too, so field outputs read zero during reset.
      instr_q <= '0;
      flags_q <= '0;
      cmd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsn_q   <= rsn_d;
      ready_q <= ready_d;
      if (accept) begin
        instr_q <= instr;
        flags_q <= flags;
      end
      if (load_cmd) cmd_q <= sdt_decode(instr_q);
    end
  end

  assign instr_ready    = ready_q;
  assign en             = (state_q == S_ISSUE) && !busy;
  assign immediate      = cmd_q.immediate;
  assign pre            = cmd_q.pre;
  assign up             = cmd_q.up;
  assign word           = cmd_q.word;
  assign write          = cmd_q.write;
  assign load           = cmd_q.load;
  assign rn             = cmd_q.rn;
  assign rd             = cmd_q.rd;
  assign offset         = cmd_q.offset;
  assign retire_valid   = (state_q == S_RETIRE);
  assign retire_skipped = retire_valid && (rsn_q == RSN_SKIP);
  assign retire_undef   = retire_valid && (rsn_q == RSN_UNDEF);
  assign retire_timeout = retire_valid && (rsn_q == RSN_TIMEOUT);

endmodule

// File: tb/tb_sdt_issue.sv
// Self-checking bench for sdt_issue: directed cases plus random instructions
// checked against a cycle-count model of the issue protocol.
module tb_sdt_issue;

  localparam int TO     = 64;
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        instr_ready;
  logic        en, immediate, pre, up, word, write, load;
  logic [3:0]  rn, rd;
  logic [11:0] offset;
  logic        busy;
  logic        retire_valid, retire_skipped, retire_undef, retire_timeout;

  int total = 0;
  int bad   = 0;

  logic [31:0] rnd_ins;
  logic [3:0]  rnd_fl;
  int          rnd_stall, rnd_blen, quiet;

  always #5 clk = ~clk;

  sdt_issue #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .flags          (flags),
    .instr_ready    (instr_ready),
    .en             (en),
    .immediate      (immediate),
    .pre            (pre),
    .up             (up),
    .word           (word),
    .write          (write),
    .load           (load),
    .rn             (rn),
    .rd             (rd),
    .offset         (offset),
    .busy           (busy),
    .retire_valid   (retire_valid),
    .retire_skipped (retire_skipped),
    .retire_undef   (retire_undef),
    .retire_timeout (retire_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition table: even codes test a predicate, odd codes its inverse; 1110 always, 1111 never.
  function automatic bit model_pass(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: return (cc == 4'hE);
    endcase
    return cc[0] ? !base : base;
  endfunction

  // One instruction: busy is held high for `stall` cycles while the command waits to
  // issue, then for `blen` cycles starting the cycle after en (0 means it never rises).
  task automatic run_op(input logic [31:0] ins, input logic [3:0] fl, input int stall,
                        input int blen, input string tag);
    bit          exp_undef, exp_issue, exp_skip, exp_to;
    int          exp_ret, e, c, en_cnt, en_c, ret_c;
    logic [5:0]  exp_bits, got_bits;
    logic [25:0] exp_cmd, got_cmd, ret_cmd;
    logic [2:0]  got_rsn;

    exp_undef = (ins[27:26] != 2'b01) || (ins[25] && (ins[11:4] != 8'h00));
    exp_issue = !exp_undef && model_pass(ins[31:28], fl);
    exp_skip  = !exp_undef && !exp_issue;
    exp_bits  = {~ins[25], ins[24], ins[23], ~ins[22], ins[21], ins[20]};
    exp_cmd   = {exp_bits, ins[19:16], ins[15:12], ins[11:0]};
    e         = 2 + stall;
    exp_to    = 1'b0;
    if (!exp_issue)      exp_ret = 2;
    else if (blen == 0)  begin exp_ret = e + 3;  exp_to = 1'b1; end
    else if (blen <= TO) exp_ret = e + 2 + blen;
    else                 begin exp_ret = e + 2 + TO; exp_to = 1'b1; end

    @(posedge clk); #1;
    instr_valid = 1'b1; instr = ins; flags = fl; busy = 1'b0;
    c = 0; en_cnt = 0; en_c = -1; ret_c = -1;
    got_cmd = '0; ret_cmd = '0; got_rsn = '0;
    while (c < BUDGET) begin
      @(negedge clk);
      if (c == 0) check({tag, ".ready"}, instr_ready, 1'b1);
      if (en) begin
        en_cnt++;
        if (en_c < 0) begin
          en_c    = c;
          got_cmd = {immediate, pre, up, word, write, load, rn, rd, offset};
        end
      end
      if (retire_valid) begin
        ret_c   = c;
        got_rsn = {retire_skipped, retire_undef, retire_timeout};
        ret_cmd = {immediate, pre, up, word, write, load, rn, rd, offset};
        break;
      end
      @(posedge clk); #1;
      c++;
      instr_valid = 1'($urandom_range(0, 1));
      instr       = $urandom;
      flags       = 4'($urandom);
      busy        = (c >= 2 && c < 2 + stall) || (en_c >= 0 && c > en_c && c <= en_c + blen);
    end

    check({tag, ".latency"}, ret_c, exp_ret);
    check({tag, ".en_count"}, en_cnt, exp_issue ? 1 : 0);
    check({tag, ".reason"}, got_rsn, {exp_skip, exp_undef, exp_to});
    if (exp_issue) begin
      check({tag, ".en_cycle"}, en_c, e);
      got_bits = got_cmd[25:20];
      check({tag, ".ctl_bits"}, got_bits, exp_bits);
      check({tag, ".regs_off"}, got_cmd[19:0], exp_cmd[19:0]);
      check({tag, ".held_to_retire"}, ret_cmd, exp_cmd);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; flags = '0; busy = 1'b0;
    #12;
    check("reset.ready", instr_ready, 1'b0);
    check("reset.en", en, 1'b0);
    check("reset.retire", {retire_valid, retire_skipped, retire_undef, retire_timeout}, 4'b0);
    check("reset.fields", {immediate, pre, up, word, write, load, rn, rd, offset}, 26'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'hE5921004, 4'b0000, 0, 6,    "ldr_imm");
    run_op(32'hE4443008, 4'b0000, 0, 3,    "strb_post");
    run_op(32'h05921004, 4'b0000, 0, 2,    "eq_skip");
    run_op(32'h05921004, 4'b0100, 0, 2,    "eq_issue");
    run_op(32'hE7921102, 4'b0000, 0, 2,    "undef_shift");
    run_op(32'hE0821003, 4'b0000, 0, 2,    "undef_class");
    run_op(32'h07921102, 4'b0000, 0, 2,    "undef_over_skip");
    run_op(32'hF5921004, 4'b1111, 0, 2,    "nv_skip");
    run_op(32'hE5921004, 4'b0000, 0, 0,    "busy_never");
    run_op(32'hE5921004, 4'b0000, 0, 1000, "busy_stuck");
    run_op(32'hE5921004, 4'b0000, 0, TO,   "busy_edge_ok");
    run_op(32'hE5921004, 4'b0000, 0, TO+1, "busy_edge_to");
    run_op(32'hE59F2FFF, 4'b0000, 3, 4,    "issue_stall");

    // Reset while the transfer unit is busy: the instruction vanishes without a report.
    @(posedge clk); #1;
    instr_valid = 1'b1; instr = 32'hE5921004; flags = '0; busy = 1'b0;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check("rst_mid.en_before", en, 1'b1);
    @(posedge clk); #1; busy = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_mid.en", en, 1'b0);
    check("rst_mid.ready", instr_ready, 1'b0);
    check("rst_mid.retire", {retire_valid, retire_skipped, retire_undef, retire_timeout}, 4'b0);
    check("rst_mid.fields", {immediate, pre, up, word, write, load, rn, rd, offset}, 26'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; busy = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.ready_after", instr_ready, 1'b1);
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (retire_valid) quiet++;
    end
    check("rst_mid.no_retire", quiet, 0);

    for (int k = 0; k < 30; k++) begin
      rnd_ins = $urandom;
      if ($urandom_range(0, 7) != 0) rnd_ins[27:26] = 2'b01;
      if (rnd_ins[25] && ($urandom_range(0, 1) != 0)) rnd_ins[11:4] = 8'h00;
      rnd_fl    = 4'($urandom);
      rnd_stall = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       rnd_blen = 0;
        1:       rnd_blen = TO - 1 + $urandom_range(0, 2);
        default: rnd_blen = $urandom_range(1, 12);
      endcase
      run_op(rnd_ins, rnd_fl, rnd_stall, rnd_blen, $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
